// File: rtl/mem_port_arbiter_if.sv
// Bundle of cache request/grant lines and the block-wide memory port shared by mem_port_arbiter.
// The arbiter connects through the slave modport; caches and memory model use the master modport.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 16
);
    logic                  i_req;
    logic [ADDR_W-1:0]     i_addr;
    logic                  i_grant;
    logic                  i_done;
    logic [4*ADDR_W-1:0]   i_data;

    logic                  d_read_req;
    logic                  d_write_req;
    logic [ADDR_W-1:0]     d_addr;
    logic [ADDR_W-1:0]     d_wdata;
    logic                  d_grant;
    logic                  d_done;
    logic [4*ADDR_W-1:0]   d_data;

    logic                  mem_read;
    logic                  mem_write;
    logic [ADDR_W-1:0]     mem_addr;
    logic [ADDR_W-1:0]     mem_wdata;
    logic [4*ADDR_W-1:0]   mem_rdata;

    logic                  busy;

    modport slave (
        input  i_req, i_addr, d_read_req, d_write_req, d_addr, d_wdata, mem_rdata,
        output i_grant, i_done, i_data, d_grant, d_done, d_data,
               mem_read, mem_write, mem_addr, mem_wdata, busy
    );

    modport master (
        output i_req, i_addr, d_read_req, d_write_req, d_addr, d_wdata, mem_rdata,
        input  i_grant, i_done, i_data, d_grant, d_done, d_data,
               mem_read, mem_write, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one block-wide memory port between I-cache and D-cache (IDLE -> BUSY -> DONE).
// Define ARB_ROUND_ROBIN_EN for round-robin tie breaking; default is fixed D-over-I priority.
module mem_port_arbiter #(
    parameter int MEM_LATENCY = 4,
    parameter int ADDR_W      = 16
) (
    input  logic               clk,
    input  logic               reset,
    mem_port_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    typedef enum logic       {WIN_I, WIN_D}     side_t;

    state_t               state_q, state_d;
    side_t                win_q, win_d;
    side_t                last_q, last_d;
    logic                 wr_q, wr_d;
    logic [3:0]           cnt_q, cnt_d;

    logic                 i_grant_q, i_grant_d;
    logic                 d_grant_q, d_grant_d;
    logic                 i_done_q, i_done_d;
    logic                 d_done_q, d_done_d;
    logic [4*ADDR_W-1:0]  i_data_q, i_data_d;
    logic [4*ADDR_W-1:0]  d_data_q, d_data_d;
    logic                 mem_read_q, mem_read_d;
    logic                 mem_write_q, mem_write_d;
    logic [ADDR_W-1:0]    mem_addr_q, mem_addr_d;
    logic [ADDR_W-1:0]    mem_wdata_q, mem_wdata_d;
    logic                 busy_q, busy_d;

    logic                 d_any;
    logic                 pick_d;
    logic                 new_wr;
    logic [ADDR_W-1:0]    req_addr;

    assign d_any = bus.d_read_req | bus.d_write_req;

`ifdef ARB_ROUND_ROBIN_EN
    // On a tie the side that did not win last time goes first.
    assign pick_d = d_any & (~bus.i_req | (last_q == WIN_I));
`else
    // last_winner is kept in this build too; the second term never changes the result.
    assign pick_d = d_any | (d_any & (last_q == WIN_D));
`endif

    assign new_wr   = pick_d & bus.d_write_req;
    assign req_addr = pick_d ? bus.d_addr : bus.i_addr;

    always_comb begin
        state_d     = state_q;
        win_d       = win_q;
        last_d      = last_q;
        wr_d        = wr_q;
        cnt_d       = cnt_q;
        i_grant_d   = 1'b0;
        d_grant_d   = 1'b0;
        i_done_d    = 1'b0;
        d_done_d    = 1'b0;
        i_data_d    = i_data_q;
        d_data_d    = d_data_q;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        mem_addr_d  = '0;
        mem_wdata_d = '0;
        busy_d      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.i_req || d_any) begin
                    state_d     = BUSY;
                    win_d       = pick_d ? WIN_D : WIN_I;
                    wr_d        = new_wr;
                    cnt_d       = 4'(MEM_LATENCY - 1);
                    i_grant_d   = ~pick_d;
                    d_grant_d   = pick_d;
                    mem_read_d  = ~new_wr;
                    mem_write_d = new_wr;
                    mem_addr_d  = new_wr ? req_addr : {req_addr[ADDR_W-1:2], 2'b00};
                    mem_wdata_d = new_wr ? bus.d_wdata : '0;
                    busy_d      = 1'b1;
                end
            end
            BUSY: begin
                busy_d    = 1'b1;
                i_grant_d = i_grant_q;
                d_grant_d = d_grant_q;
                if (cnt_q == 4'd0) begin
                    state_d  = DONE;
                    i_done_d = (win_q == WIN_I);
                    d_done_d = (win_q == WIN_D);
                    if (!wr_q) begin
                        if (win_q == WIN_D) d_data_d = bus.mem_rdata;
                        else                i_data_d = bus.mem_rdata;
                    end
                end else begin
                    cnt_d       = cnt_q - 4'd1;
                    mem_read_d  = mem_read_q;
                    mem_write_d = mem_write_q;
                    mem_addr_d  = mem_addr_q;
                    mem_wdata_d = mem_wdata_q;
                end
            end
            DONE: begin
                state_d = IDLE;
                last_d  = win_q;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            win_q       <= WIN_I;
            last_q      <= WIN_I;
            wr_q        <= 1'b0;
            cnt_q       <= '0;
            i_grant_q   <= 1'b0;
            d_grant_q   <= 1'b0;
            i_done_q    <= 1'b0;
            d_done_q    <= 1'b0;
            i_data_q    <= '0;
            d_data_q    <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            win_q       <= win_d;
            last_q      <= last_d;
            wr_q        <= wr_d;
            cnt_q       <= cnt_d;
            i_grant_q   <= i_grant_d;
            d_grant_q   <= d_grant_d;
            i_done_q    <= i_done_d;
            d_done_q    <= d_done_d;
            i_data_q    <= i_data_d;
            d_data_q    <= d_data_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.i_grant   = i_grant_q;
    assign bus.d_grant   = d_grant_q;
    assign bus.i_done    = i_done_q;
    assign bus.d_done    = d_done_q;
    assign bus.i_data    = i_data_q;
    assign bus.d_data    = d_data_q;
    assign bus.mem_read  = mem_read_q;
    assign bus.mem_write = mem_write_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: completions are predicted when requests are driven.
// Honours ARB_ROUND_ROBIN_EN for the expected tie-break order.
module tb_mem_port_arbiter;
    localparam int LAT = 4;
    localparam int AW  = 16;

    logic clk = 1'b0;
    logic reset;

    mem_port_arbiter_if #(.ADDR_W(AW)) bus ();

    mem_port_arbiter #(.MEM_LATENCY(LAT), .ADDR_W(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          side_d;
        bit          is_wr;
        logic [63:0] data;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned done_cnt = 0;
    logic [63:0] d_last   = '0;
    bit          igrant_seen = 1'b0;

    function automatic logic [63:0] blk(input logic [15:0] a);
        return {a + 16'h4324, a + 16'h3213, a + 16'h2102, a + 16'h0FF1};
    endfunction

    always_comb bus.mem_rdata = blk(bus.mem_addr);

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic push(input bit side_d, input bit is_wr, input logic [15:0] addr);
        exp_t e;
        e.side_d = side_d;
        e.is_wr  = is_wr;
        e.data   = is_wr ? 64'd0 : blk({addr[15:2], 2'b00});
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            check("grant_onehot", 64'(bus.i_grant & bus.d_grant), 64'd0);
            if (bus.i_grant) igrant_seen = 1'b1;
            if (bus.i_done || bus.d_done) begin
                done_cnt++;
                if (sb.size() == 0) begin
                    check("unexpected_done", 64'd1, 64'd0);
                end else begin
                    mon_e = sb.pop_front();
                    check("done_side", 64'(bus.d_done), 64'(mon_e.side_d));
                    check("done_onehot", 64'(bus.i_done & bus.d_done), 64'd0);
                    if (mon_e.side_d) begin
                        if (mon_e.is_wr) begin
                            check("d_data_wr_hold", bus.d_data, d_last);
                        end else begin
                            check("d_data", bus.d_data, mon_e.data);
                            d_last = mon_e.data;
                        end
                    end else begin
                        check("i_data", bus.i_data, mon_e.data);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned start;
        int unsigned target;
        reset           = 1'b1;
        bus.i_req       = 1'b0;
        bus.i_addr      = '0;
        bus.d_read_req  = 1'b0;
        bus.d_write_req = 1'b0;
        bus.d_addr      = '0;
        bus.d_wdata     = '0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_busy",   64'(bus.busy), 64'd0);
        check("rst_grants", 64'({bus.i_grant, bus.d_grant}), 64'd0);
        check("rst_dones",  64'({bus.i_done, bus.d_done}), 64'd0);
        check("rst_mem",    64'({bus.mem_read, bus.mem_write}), 64'd0);
        check("rst_addr",   64'(bus.mem_addr), 64'd0);
        check("rst_wdata",  64'(bus.mem_wdata), 64'd0);
        check("rst_i_data", bus.i_data, 64'd0);
        check("rst_d_data", bus.d_data, 64'd0);
        reset = 1'b0;

        // I-cache block fetch
        bus.i_req  = 1'b1;
        bus.i_addr = 16'h0123;
        push(1'b0, 1'b0, 16'h0123);
        for (int k = 1; k <= 6; k++) begin
            step();
            check("t1_mem_read", 64'(bus.mem_read), 64'(k >= 1 && k <= 4));
            if (k <= 4) check("t1_mem_addr", 64'(bus.mem_addr), 64'h0120);
            check("t1_busy", 64'(bus.busy), 64'(k <= 5));
            check("t1_i_done", 64'(bus.i_done), 64'(k == 5));
            if (k == 5) begin
                check("t1_i_data", bus.i_data, 64'h4444_3333_2222_1111);
                bus.i_req = 1'b0;
            end
        end

        // Simultaneous I and D reads
        bus.i_req      = 1'b1;
        bus.i_addr     = 16'h0456;
        bus.d_read_req = 1'b1;
        bus.d_addr     = 16'h0789;
        push(1'b1, 1'b0, 16'h0789);
        push(1'b0, 1'b0, 16'h0456);
        for (int k = 1; k <= 12; k++) begin
            step();
            check("t3_d_grant", 64'(bus.d_grant), 64'(k >= 1 && k <= 5));
            check("t3_i_grant", 64'(bus.i_grant), 64'(k >= 7 && k <= 11));
            check("t3_d_done",  64'(bus.d_done),  64'(k == 5));
            check("t3_i_done",  64'(bus.i_done),  64'(k == 11));
            if (k == 5)  bus.d_read_req = 1'b0;
            if (k == 11) bus.i_req = 1'b0;
        end

        // D-cache write-through
        bus.d_write_req = 1'b1;
        bus.d_addr      = 16'h0042;
        bus.d_wdata     = 16'hBEEF;
        push(1'b1, 1'b1, 16'h0042);
        for (int k = 1; k <= 6; k++) begin
            step();
            check("t2_mem_write", 64'(bus.mem_write), 64'(k >= 1 && k <= 4));
            check("t2_mem_read",  64'(bus.mem_read), 64'd0);
            if (k <= 4) begin
                check("t2_mem_addr",  64'(bus.mem_addr), 64'h0042);
                check("t2_mem_wdata", 64'(bus.mem_wdata), 64'hBEEF);
            end
            check("t2_d_done", 64'(bus.d_done), 64'(k == 5));
            if (k == 5) bus.d_write_req = 1'b0;
        end

        // Read and write together resolve to a write at the full address
        bus.d_read_req  = 1'b1;
        bus.d_write_req = 1'b1;
        bus.d_addr      = 16'h0007;
        bus.d_wdata     = 16'h1234;
        push(1'b1, 1'b1, 16'h0007);
        for (int k = 1; k <= 6; k++) begin
            step();
            check("t6_mem_write", 64'(bus.mem_write), 64'(k >= 1 && k <= 4));
            check("t6_mem_read",  64'(bus.mem_read), 64'd0);
            if (k <= 4) check("t6_mem_addr", 64'(bus.mem_addr), 64'h0007);
            if (k == 5) begin
                bus.d_read_req  = 1'b0;
                bus.d_write_req = 1'b0;
            end
        end

        // Asynchronous reset in the middle of a fetch
        bus.i_req  = 1'b1;
        bus.i_addr = 16'h0ABC;
        step();
        step();
        check("t5_pre_read", 64'(bus.mem_read), 64'd1);
        reset = 1'b1;
        #1;
        check("t5_mem_read", 64'(bus.mem_read), 64'd0);
        check("t5_i_grant",  64'(bus.i_grant), 64'd0);
        check("t5_busy",     64'(bus.busy), 64'd0);
        check("t5_i_data",   bus.i_data, 64'd0);
        check("t5_d_data",   bus.d_data, 64'd0);
        d_last = '0;
        #1;
        reset = 1'b0;
        push(1'b0, 1'b0, 16'h0ABC);
        for (int k = 1; k <= 6; k++) begin
            step();
            check("t5_i_done", 64'(bus.i_done), 64'(k == LAT + 1));
            if (k == LAT + 1) bus.i_req = 1'b0;
        end

        // Both sides requesting continuously
        start       = done_cnt;
        igrant_seen = 1'b0;
        bus.i_addr  = 16'h0300;
        bus.d_addr  = 16'h0200;
`ifdef ARB_ROUND_ROBIN_EN
        target = 4;
        push(1'b1, 1'b0, 16'h0200);
        push(1'b0, 1'b0, 16'h0300);
        push(1'b1, 1'b0, 16'h0200);
        push(1'b0, 1'b0, 16'h0300);
`else
        target = 3;
        push(1'b1, 1'b0, 16'h0200);
        push(1'b1, 1'b0, 16'h0200);
        push(1'b1, 1'b0, 16'h0200);
`endif
        bus.i_req      = 1'b1;
        bus.d_read_req = 1'b1;
        for (int c = 0; c < 100 && done_cnt < start + target; c++) step();
        bus.i_req      = 1'b0;
        bus.d_read_req = 1'b0;
        check("t4_done_count", 64'(done_cnt - start), 64'(target));
`ifdef ARB_ROUND_ROBIN_EN
        check("t4_i_granted", 64'(igrant_seen), 64'd1);
`else
        check("t4_i_starved", 64'(igrant_seen), 64'd0);
`endif
        repeat (LAT + 3) step();
        check("t4_idle", 64'(bus.busy), 64'd0);
        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
